// File: rtl/trackball_emu.sv
// Digital joystick to trackball emulator: a free-running motion tick drives two
// independent per-axis accelerators that step 8-bit position counters.
module trackball_emu #(
    parameter int TICK_DIV    = 20000,
    parameter int ACCEL_TICKS = 8,
    parameter int MAX_RATE    = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Left,
    input  logic       Right,
    input  logic       Up,
    input  logic       Down,
    input  logic       Hold,
    output logic [7:0] PosX,
    output logic [7:0] PosY,
    output logic       DirX,
    output logic       DirY,
    output logic       Tick
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAMP = 2'd1,
        ST_FULL = 2'd2
    } axis_state_e;

    typedef struct packed {
        axis_state_e st;
        logic [3:0]  rate;
        logic [7:0]  hcnt;
        logic [7:0]  pos;
        logic        dir;
    } axis_t;

    localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
    localparam logic [3:0]  RATE_MAX  = 4'(MAX_RATE);
    localparam logic [8:0]  ACCEL_LIM = 9'(ACCEL_TICKS);
    localparam axis_t AXIS_RST = '{st: ST_IDLE, rate: 4'd1, hcnt: 8'd0, pos: 8'd0, dir: 1'b1};

    if (TICK_DIV < 2 || TICK_DIV > 65535) begin : g_bad_tick_div
        $error("trackball_emu: TICK_DIV out of range 2..65535");
    end
    if (ACCEL_TICKS < 1 || ACCEL_TICKS > 255) begin : g_bad_accel
        $error("trackball_emu: ACCEL_TICKS out of range 1..255");
    end
    if (MAX_RATE < 1 || MAX_RATE > 15) begin : g_bad_rate
        $error("trackball_emu: MAX_RATE out of range 1..15");
    end

    // One axis step. plus/minus are the already-resolved command (never both 1);
    // adv is high only on an unheld tick.
    function automatic axis_t axis_next(input axis_t cur, input logic plus,
                                        input logic minus, input logic adv);
        axis_t      nxt;
        logic [3:0] step;
        logic [8:0] hc_inc;
        nxt    = cur;
        step   = 4'd0;
        hc_inc = {1'b0, cur.hcnt} + 9'd1;
        if (adv) begin
            if (!plus && !minus) begin
                nxt.st   = ST_IDLE;
                nxt.rate = 4'd1;
                nxt.hcnt = 8'd0;
            end else if (cur.st == ST_IDLE || cur.dir != plus) begin
                // Fresh start, also taken on a direction reversal
                step     = 4'd1;
                nxt.rate = 4'd1;
                nxt.hcnt = 8'd1;
                nxt.dir  = plus;
                nxt.st   = (RATE_MAX == 4'd1) ? ST_FULL : ST_RAMP;
            end else if (cur.st == ST_RAMP) begin
                step = cur.rate;
                if (hc_inc >= ACCEL_LIM) begin
                    nxt.rate = cur.rate + 4'd1;
                    nxt.hcnt = 8'd0;
                    if (cur.rate + 4'd1 >= RATE_MAX) begin
                        nxt.st = ST_FULL;
                    end
                end else begin
                    nxt.hcnt = hc_inc[7:0];
                end
            end else begin
                step = RATE_MAX;
            end
            nxt.pos = plus ? (cur.pos + {4'd0, step}) : (cur.pos - {4'd0, step});
        end
        return nxt;
    endfunction

    logic [15:0] tick_cnt_q, tick_cnt_d;
    logic        tick_pulse;
    axis_t       axis_x_q, axis_x_d;
    axis_t       axis_y_q, axis_y_d;
    logic        x_plus, x_minus, y_plus, y_minus;
    logic        advance;

    assign tick_pulse = (tick_cnt_q == TICK_LAST);
    assign advance    = tick_pulse & ~Hold;

    always_comb begin
        tick_cnt_d = tick_pulse ? 16'd0 : tick_cnt_q + 16'd1;
        x_plus     = Right & ~Left;
        x_minus    = Left & ~Right;
        y_plus     = Down & ~Up;
        y_minus    = Up & ~Down;
        axis_x_d   = axis_next(axis_x_q, x_plus, x_minus, advance);
        axis_y_d   = axis_next(axis_y_q, y_plus, y_minus, advance);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            tick_cnt_q <= 16'd0;
            axis_x_q   <= AXIS_RST;
            axis_y_q   <= AXIS_RST;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            axis_x_q   <= axis_x_d;
            axis_y_q   <= axis_y_d;
        end
    end

    assign Tick = tick_pulse;
    assign PosX = axis_x_q.pos;
    assign PosY = axis_y_q.pos;
    assign DirX = axis_x_q.dir;
    assign DirY = axis_y_q.dir;

endmodule

// File: tb/tb_trackball_emu.sv
// Bench for trackball_emu: directed scenarios plus randomized ticks checked
// against a run-length model of the acceleration rules.
module tb_trackball_emu;

    localparam int TD = 4;
    localparam int AT = 2;
    localparam int MR = 3;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Left = 1'b0, Right = 1'b0, Up = 1'b0, Down = 1'b0, Hold = 1'b0;
    logic [7:0] PosX, PosY;
    logic       DirX, DirY, Tick;

    int checks = 0;
    int failures = 0;

    // Model: position, last direction and length of the current same-direction run
    int   mpos[2];
    bit   mdir[2];
    int   mrun[2];
    int   exp_pre_x, exp_pre_y;
    logic [7:0] pre_x, pre_y;

    trackball_emu #(.TICK_DIV(TD), .ACCEL_TICKS(AT), .MAX_RATE(MR)) dut (
        .Clk(Clk), .Reset(Reset), .Left(Left), .Right(Right), .Up(Up),
        .Down(Down), .Hold(Hold), .PosX(PosX), .PosY(PosY), .DirX(DirX),
        .DirY(DirY), .Tick(Tick)
    );

    always #5 Clk = ~Clk;

    function automatic int rate_for(input int n);
        int r;
        r = 1 + (n - 1) / AT;
        return (r > MR) ? MR : r;
    endfunction

    task automatic model_reset();
        for (int a = 0; a < 2; a++) begin
            mpos[a] = 0;
            mdir[a] = 1'b1;
            mrun[a] = 0;
        end
    endtask

    task automatic model_tick(input bit l, input bit r, input bit u, input bit d, input bit h);
        int cmd[2];
        if (h) return;
        cmd[0] = (r && !l) ? 1 : ((l && !r) ? -1 : 0);
        cmd[1] = (d && !u) ? 1 : ((u && !d) ? -1 : 0);
        for (int a = 0; a < 2; a++) begin
            if (cmd[a] == 0) begin
                mrun[a] = 0;
            end else begin
                if (mrun[a] == 0 || mdir[a] != (cmd[a] > 0)) mrun[a] = 1;
                else mrun[a] = mrun[a] + 1;
                mpos[a] = (mpos[a] + cmd[a] * rate_for(mrun[a]) + 256) % 256;
                mdir[a] = (cmd[a] > 0);
            end
        end
    endtask

    // Scribbles random inputs between ticks, applies the wanted inputs in the
    // Tick cycle, then returns at the negedge after the registered update.
    task automatic run_tick(input bit l, input bit r, input bit u, input bit d, input bit h);
        int n;
        n = 0;
        while (Tick !== 1'b1) begin
            if (n >= 3 * TD) begin
                $display("FAIL tick_timeout waited=%0d cycles, required a Tick within %0d", n, TD);
                $fatal(1, "tick generator stalled");
            end
            {Left, Right, Up, Down, Hold} = 5'($urandom);
            @(negedge Clk);
            n++;
        end
        Left = l; Right = r; Up = u; Down = d; Hold = h;
        pre_x = PosX;
        pre_y = PosY;
        exp_pre_x = mpos[0];
        exp_pre_y = mpos[1];
        model_tick(l, r, u, d, h);
        @(negedge Clk);
        {Left, Right, Up, Down, Hold} = 5'd0;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        int n;
        @(negedge Clk);
        checks++;
        if ({PosX, PosY, DirX, DirY, Tick} !== {8'd0, 8'd0, 1'b1, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL reset_state got PosX=%0d PosY=%0d DirX=%0b DirY=%0b Tick=%0b, want 0 0 1 1 0",
                     PosX, PosY, DirX, DirY, Tick);
        end
        Reset = 1'b0;
        model_reset();
        // Release cycle counts as cycle 1, so Tick shows after TD-1 more edges
        n = 0;
        while (Tick !== 1'b1 && n < 3 * TD) begin
            @(negedge Clk);
            n++;
        end
        checks++;
        if (n != TD - 1) begin
            failures++;
            $display("FAIL first_tick edges=%0d required=%0d", n, TD - 1);
        end
        @(negedge Clk);
        checks++;
        if (Tick !== 1'b0) begin
            failures++;
            $display("FAIL tick_width got Tick=%0b want 0", Tick);
        end
        n = 1;
        while (Tick !== 1'b1 && n < 3 * TD) begin
            @(negedge Clk);
            n++;
        end
        checks++;
        if (n != TD) begin
            failures++;
            $display("FAIL tick_period got=%0d required=%0d", n, TD);
        end
    endtask

    task automatic test_idle();
        int ticks, bad_gap, bad_out, last;
        do_reset();
        ticks = 0; bad_gap = 0; bad_out = 0; last = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge Clk);
            if (Tick === 1'b1) begin
                ticks++;
                if (last >= 0 && k - last != TD) bad_gap++;
                last = k;
            end
            if ({PosX, PosY, DirX, DirY} !== {8'd0, 8'd0, 1'b1, 1'b1}) bad_out++;
        end
        checks++;
        if (ticks != 10 || bad_gap != 0) begin
            failures++;
            $display("FAIL idle_ticks got count=%0d bad_gaps=%0d, want 10 and 0", ticks, bad_gap);
        end
        checks++;
        if (bad_out != 0) begin
            failures++;
            $display("FAIL idle_outputs got %0d cycles off reset values, want 0", bad_out);
        end
    endtask

    task automatic test_right_ramp();
        int inc[8] = '{1, 1, 2, 2, 3, 3, 3, 3};
        logic [7:0] prev;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            prev = PosX;
            run_tick(0, 1, 0, 0, 0);
            checks++;
            if (8'(PosX - prev) !== 8'(inc[i]) || PosX !== 8'(mpos[0])) begin
                failures++;
                $display("FAIL ramp_step%0d got delta=%0d PosX=%0d, want delta=%0d PosX=%0d",
                         i, 8'(PosX - prev), PosX, inc[i], mpos[0]);
            end
        end
        checks++;
        if (PosX !== 8'd18 || DirX !== 1'b1 || PosY !== 8'd0) begin
            failures++;
            $display("FAIL ramp_final got PosX=%0d DirX=%0b PosY=%0d, want 18 1 0", PosX, DirX, PosY);
        end
    endtask

    task automatic test_left_wrap();
        logic [7:0] want[3] = '{8'd0, 8'd255, 8'd253};
        do_reset();
        run_tick(0, 1, 0, 0, 0);
        checks++;
        if (PosX !== 8'd1) begin
            failures++;
            $display("FAIL wrap_setup got PosX=%0d want 1", PosX);
        end
        for (int i = 0; i < 3; i++) begin
            run_tick(1, 0, 0, 0, 0);
            checks++;
            if (PosX !== want[i] || DirX !== 1'b0) begin
                failures++;
                $display("FAIL wrap_left%0d got PosX=%0d DirX=%0b, want %0d 0", i, PosX, DirX, want[i]);
            end
        end
        run_tick(1, 1, 0, 0, 0);
        checks++;
        if (PosX !== 8'd253 || DirX !== 1'b0) begin
            failures++;
            $display("FAIL opposing got PosX=%0d DirX=%0b, want 253 0", PosX, DirX);
        end
        run_tick(1, 0, 0, 0, 0);
        checks++;
        if (PosX !== 8'd252) begin
            failures++;
            $display("FAIL restart_after_idle got PosX=%0d want 252", PosX);
        end
    endtask

    task automatic test_reverse_diag();
        logic [7:0] wx[2] = '{8'd4, 8'd2};
        logic [7:0] wy[2] = '{8'd1, 8'd2};
        do_reset();
        for (int i = 0; i < 4; i++) run_tick(0, 1, 0, 0, 0);
        checks++;
        if (PosX !== 8'd6) begin
            failures++;
            $display("FAIL rev_setup got PosX=%0d want 6", PosX);
        end
        run_tick(1, 0, 0, 0, 0);
        checks++;
        if (PosX !== 8'd5 || DirX !== 1'b0) begin
            failures++;
            $display("FAIL reverse got PosX=%0d DirX=%0b, want 5 0", PosX, DirX);
        end
        for (int i = 0; i < 2; i++) begin
            run_tick(1, 0, 0, 1, 0);
            checks++;
            if (PosX !== wx[i] || PosY !== wy[i] || DirY !== 1'b1) begin
                failures++;
                $display("FAIL diag%0d got PosX=%0d PosY=%0d DirY=%0b, want %0d %0d 1",
                         i, PosX, PosY, DirY, wx[i], wy[i]);
            end
        end
    endtask

    task automatic test_hold();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            run_tick(0, 0, 1, 0, 1);
            checks++;
            if (PosY !== 8'd0 || DirY !== 1'b1) begin
                failures++;
                $display("FAIL hold%0d got PosY=%0d DirY=%0b, want 0 1", i, PosY, DirY);
            end
        end
        run_tick(0, 0, 1, 0, 0);
        checks++;
        if (PosY !== 8'd255 || DirY !== 1'b0) begin
            failures++;
            $display("FAIL hold_release got PosY=%0d DirY=%0b, want 255 0", PosY, DirY);
        end
    endtask

    task automatic test_reset_midramp();
        do_reset();
        for (int i = 0; i < 4; i++) run_tick(0, 1, 0, 0, 0);
        Right = 1'b1;
        Reset = 1'b1;
        #1;
        checks++;
        if (PosX !== 8'd0 || DirX !== 1'b1 || Tick !== 1'b0) begin
            failures++;
            $display("FAIL async_reset got PosX=%0d DirX=%0b Tick=%0b, want 0 1 0", PosX, DirX, Tick);
        end
        @(negedge Clk);
        Reset = 1'b0;
        model_reset();
        run_tick(0, 1, 0, 0, 0);
        checks++;
        if (PosX !== 8'd1) begin
            failures++;
            $display("FAIL post_reset_tick got PosX=%0d want 1", PosX);
        end
    endtask

    task automatic test_random();
        bit l, r, u, d, h;
        do_reset();
        for (int i = 0; i < 150; i++) begin
            l = 1'($urandom); r = 1'($urandom); u = 1'($urandom); d = 1'($urandom);
            h = ($urandom_range(0, 4) == 0);
            // Bias toward held single directions so ramps reach full rate
            if ($urandom_range(0, 2) != 0) begin
                l = (i / 10) % 2 == 1; r = !l;
                u = (i / 7) % 2 == 1; d = !u;
            end
            run_tick(l, r, u, d, h);
            checks++;
            if (pre_x !== 8'(exp_pre_x) || pre_y !== 8'(exp_pre_y)) begin
                failures++;
                $display("FAIL rnd_latency%0d got PosX=%0d PosY=%0d in Tick cycle, want %0d %0d",
                         i, pre_x, pre_y, exp_pre_x, exp_pre_y);
            end
            checks++;
            if (PosX !== 8'(mpos[0]) || PosY !== 8'(mpos[1]) || DirX !== mdir[0] || DirY !== mdir[1]) begin
                failures++;
                $display("FAIL rnd_tick%0d got X=%0d Y=%0d dx=%0b dy=%0b, want X=%0d Y=%0d dx=%0b dy=%0b",
                         i, PosX, PosY, DirX, DirY, mpos[0], mpos[1], mdir[0], mdir[1]);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_idle();
        test_right_ramp();
        test_left_wrap();
        test_reverse_diag();
        test_hold();
        test_reset_midramp();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
